lot_gate_controller: RTL and testbench

- Sequencer for the parking-lot occupancy counter. Decodes photo-sensor sequences on one entry lane and one exit lane into complete car passages.
- Opens and closes the lane gates, and refuses entry when the lot is full.
- Arbitrates the single counter update port, so at most one increment or decrement pulse is issued per cycle.
- Sits between the debounced sensor inputs and the counter's in/out pulse inputs; reads back the counter's car count.

---
 rtl/lot_gate_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_lot_gate_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lot_gate_controller.sv
// Parking-lot gate sequencer: decodes entry/exit sensor passages, drives the lane gates
// and issues single inc/dec pulses to the occupancy counter. Optional stats: LOT_STATS_EN.
module lot_gate_controller #(
    parameter int CAPACITY  = 25,
    parameter int CW        = 5,
    parameter int GATE_HOLD = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ent_a,
    input  logic          ent_b,
    input  logic          ext_a,
    input  logic          ext_b,
    input  logic [CW-1:0] occupancy,
    output logic          inc,
    output logic          dec,
    output logic          ent_gate,
    output logic          ext_gate,
    output logic          full,
    output logic          empty,
    output logic          underflow_err,
`ifdef LOT_STATS_EN
    output logic [15:0]   total_entries,
    output logic [7:0]    denied_count,
`endif
    output logic [2:0]    ent_state_dbg_o,
    output logic [2:0]    ext_state_dbg_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_A       = 3'd1,
        S_AB      = 3'd2,
        S_B       = 3'd3,
        S_BLOCKED = 3'd4
    } lane_state_e;

    localparam int EW = CW + 2;

    lane_state_e ent_state_q, ent_state_d, ext_state_q, ext_state_d;
    logic        ent_pend_q, ent_pend_d, ext_pend_q, ext_pend_d;
    logic        inc_q, inc_d, dec_q, dec_d, rr_q, rr_d;
    logic        ent_gate_q, ent_gate_d, ext_gate_q, ext_gate_d;
    logic [3:0]  ent_hold_q, ent_hold_d, ext_hold_q, ext_hold_d;
    logic        full_q, full_d, empty_q, empty_d, uf_q, uf_d;
    logic        ent_done, ext_done, ent_arrive, ext_arrive, ent_to_idle, ext_to_idle;
    logic        serve_ent, serve_ext, eff_zero;
    logic [EW-1:0] eff;

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_state_q <= S_IDLE;
            ext_state_q <= S_IDLE;
            ent_pend_q  <= 1'b0;
            ext_pend_q  <= 1'b0;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            rr_q        <= 1'b0;
            ent_gate_q  <= 1'b0;
            ext_gate_q  <= 1'b0;
            ent_hold_q  <= 4'd0;
            ext_hold_q  <= 4'd0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            uf_q        <= 1'b0;
        end else begin
            ent_state_q <= ent_state_d;
            ext_state_q <= ext_state_d;
            ent_pend_q  <= ent_pend_d;
            ext_pend_q  <= ext_pend_d;
            inc_q       <= inc_d;
            dec_q       <= dec_d;
            rr_q        <= rr_d;
            ent_gate_q  <= ent_gate_d;
            ext_gate_q  <= ext_gate_d;
            ent_hold_q  <= ent_hold_d;
            ext_hold_q  <= ext_hold_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            uf_q        <= uf_d;
        end
    end

    // Entry lane: an arrival while full parks the lane in BLOCKED until the sensors clear.
    always_comb begin
        ent_state_d = ent_state_q;
        ent_done    = 1'b0;
        ent_arrive  = 1'b0;
        ent_to_idle = 1'b0;
        case (ent_state_q)
            S_IDLE: begin
                if (ent_a && !ent_b) begin
                    if (full_q) begin
                        ent_state_d = S_BLOCKED;
                    end else begin
                        ent_state_d = S_A;
                        ent_arrive  = 1'b1;
                    end
                end
            end
            S_A: begin
                if (ent_a && ent_b) begin
                    ent_state_d = S_AB;
                end else if (!ent_a && !ent_b) begin
                    ent_state_d = S_IDLE;
                    ent_to_idle = 1'b1;
                end
            end
            S_AB: begin
                if (!ent_a && ent_b)      ent_state_d = S_B;
                else if (ent_a && !ent_b) ent_state_d = S_A;
            end
            S_B: begin
                if (!ent_a && !ent_b) begin
                    ent_state_d = S_IDLE;
                    ent_done    = 1'b1;
                    ent_to_idle = 1'b1;
                end else if (ent_a && ent_b) begin
                    ent_state_d = S_AB;
                end
            end
            S_BLOCKED: begin
                if (!ent_a && !ent_b) ent_state_d = S_IDLE;
            end
            default: ent_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ext_state_d = ext_state_q;
        ext_done    = 1'b0;
        ext_arrive  = 1'b0;
        ext_to_idle = 1'b0;
        case (ext_state_q)
            S_IDLE: begin
                if (ext_a && !ext_b) begin
                    ext_state_d = S_A;
                    ext_arrive  = 1'b1;
                end
            end
            S_A: begin
                if (ext_a && ext_b) begin
                    ext_state_d = S_AB;
                end else if (!ext_a && !ext_b) begin
                    ext_state_d = S_IDLE;
                    ext_to_idle = 1'b1;
                end
            end
            S_AB: begin
                if (!ext_a && ext_b)      ext_state_d = S_B;
                else if (ext_a && !ext_b) ext_state_d = S_A;
            end
            S_B: begin
                if (!ext_a && !ext_b) begin
                    ext_state_d = S_IDLE;
                    ext_done    = 1'b1;
                    ext_to_idle = 1'b1;
                end else if (ext_a && ext_b) begin
                    ext_state_d = S_AB;
                end
            end
            default: ext_state_d = S_IDLE;
        endcase
    end

    // Effective count includes passages already decoded but not yet seen by the counter.
    always_comb begin
        eff      = EW'(occupancy) + EW'(ent_pend_q | inc_q) - EW'(ext_pend_q | dec_q);
        eff_zero = (eff == '0);
        full_d   = !eff[EW-1] && (eff >= EW'(CAPACITY));
        empty_d  = eff_zero;
    end

    always_comb begin
        serve_ent  = ent_pend_q && (!ext_pend_q || !rr_q);
        serve_ext  = ext_pend_q && (!ent_pend_q || rr_q);
        rr_d       = (ent_pend_q && ext_pend_q) ? !rr_q : rr_q;
        inc_d      = serve_ent;
        dec_d      = serve_ext;
        ent_pend_d = (ent_pend_q && !serve_ent) || ent_done;
        ext_pend_d = (ext_pend_q && !serve_ext) || (ext_done && !eff_zero);
        uf_d       = uf_q || (ext_done && eff_zero);
    end

    // Gate hold: loaded on return to IDLE, gate drops on the edge the count runs out.
    always_comb begin
        ent_gate_d = ent_gate_q;
        ent_hold_d = ent_hold_q;
        ext_gate_d = ext_gate_q;
        ext_hold_d = ext_hold_q;
        if (ent_arrive) begin
            ent_gate_d = 1'b1;
            ent_hold_d = 4'd0;
        end else if (ent_to_idle) begin
            ent_hold_d = 4'(GATE_HOLD);
        end else if (ent_hold_q != 4'd0) begin
            ent_hold_d = ent_hold_q - 4'd1;
            if (ent_hold_q == 4'd1) ent_gate_d = 1'b0;
        end
        if (ext_arrive) begin
            ext_gate_d = 1'b1;
            ext_hold_d = 4'd0;
        end else if (ext_to_idle) begin
            ext_hold_d = 4'(GATE_HOLD);
        end else if (ext_hold_q != 4'd0) begin
            ext_hold_d = ext_hold_q - 4'd1;
            if (ext_hold_q == 4'd1) ext_gate_d = 1'b0;
        end
    end

`ifdef LOT_STATS_EN
    logic [15:0] total_q;
    logic [7:0]  denied_q;
    logic        ent_deny;

    assign ent_deny = (ent_state_q == S_IDLE) && (ent_state_d == S_BLOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            total_q  <= 16'd0;
            denied_q <= 8'd0;
        end else begin
            if (inc_q && (total_q != 16'hFFFF)) total_q <= total_q + 16'd1;
            if (ent_deny && (denied_q != 8'hFF)) denied_q <= denied_q + 8'd1;
        end
    end

    assign total_entries = total_q;
    assign denied_count  = denied_q;
`endif

    assign inc             = inc_q;
    assign dec             = dec_q;
    assign ent_gate        = ent_gate_q;
    assign ext_gate        = ext_gate_q;
    assign full            = full_q;
    assign empty           = empty_q;
    assign underflow_err   = uf_q;
    assign ent_state_dbg_o = ent_state_q;
    assign ext_state_dbg_o = ext_state_q;

endmodule

// File: tb/tb_lot_gate_controller.sv
// Bench for lot_gate_controller: directed scenarios, then random sensor traffic checked
// against a passage-level reference model that also plays the occupancy counter.
module tb_lot_gate_controller;
    localparam int CAPACITY  = 25;
    localparam int CW        = 5;
    localparam int GATE_HOLD = 4;

    logic          clk;
    logic          reset;
    logic          ent_a, ent_b, ext_a, ext_b;
    logic [CW-1:0] occupancy;
    logic          inc, dec, ent_gate, ext_gate, full, empty, underflow_err;
    logic [2:0]    ent_state_dbg_o, ext_state_dbg_o;
`ifdef LOT_STATS_EN
    logic [15:0]   total_entries;
    logic [7:0]    denied_count;
`endif

    lot_gate_controller #(.CAPACITY(CAPACITY), .CW(CW), .GATE_HOLD(GATE_HOLD)) dut (
        .clk(clk), .reset(reset),
        .ent_a(ent_a), .ent_b(ent_b), .ext_a(ext_a), .ext_b(ext_b),
        .occupancy(occupancy),
        .inc(inc), .dec(dec), .ent_gate(ent_gate), .ext_gate(ext_gate),
        .full(full), .empty(empty), .underflow_err(underflow_err),
`ifdef LOT_STATS_EN
        .total_entries(total_entries), .denied_count(denied_count),
`endif
        .ent_state_dbg_o(ent_state_dbg_o), .ext_state_dbg_o(ext_state_dbg_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: lane progress is a position 0..3 along 00,10,11,01 (00 after 01 = 4).
    int m_pos[2];
    bit m_blk;
    bit m_pend[2];
    bit m_gate[2];
    int m_hold[2];
    bit m_inc, m_dec, m_rr, m_full, m_empty, m_uf;
    int m_occ, m_total, m_denied;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pat_pos(input bit a, input bit b, input int cur);
        if (a && !b) return 1;
        if (a && b)  return 2;
        if (!a && b) return 3;
        return (cur == 3) ? 4 : 0;
    endfunction

    task automatic counter_apply();
        m_occ = m_occ + int'(m_inc) - int'(m_dec);
        if (m_occ < 0)  m_occ = 0;
        if (m_occ > 31) m_occ = 31;
        if (m_inc && m_total < 65535) m_total++;
    endtask

    task automatic model_reset();
        counter_apply();
        for (int i = 0; i < 2; i++) begin
            m_pos[i] = 0; m_pend[i] = 0; m_gate[i] = 0; m_hold[i] = 0;
        end
        m_blk = 0; m_inc = 0; m_dec = 0; m_rr = 0;
        m_full = 0; m_empty = 1; m_uf = 0; m_total = 0; m_denied = 0;
    endtask

    task automatic model_update();
        int eff, q;
        bit comp[2], arrive[2], to_idle[2], sa[2], sb[2];
        bit serve_e, serve_x;
        sa[0] = ent_a; sb[0] = ent_b; sa[1] = ext_a; sb[1] = ext_b;
        eff = m_occ + int'(m_pend[0] | m_inc) - int'(m_pend[1] | m_dec);
        for (int i = 0; i < 2; i++) begin
            comp[i] = 0; arrive[i] = 0; to_idle[i] = 0;
            if (i == 0 && m_blk) begin
                if (!sa[i] && !sb[i]) m_blk = 0;
            end else begin
                q = pat_pos(sa[i], sb[i], m_pos[i]);
                if (i == 0 && m_pos[i] == 0 && q == 1 && m_full) begin
                    m_blk = 1;
                    if (m_denied < 255) m_denied++;
                end else if (q == m_pos[i] + 1) begin
                    if (q == 4) begin
                        comp[i] = 1; to_idle[i] = 1; m_pos[i] = 0;
                    end else begin
                        if (m_pos[i] == 0) arrive[i] = 1;
                        m_pos[i] = q;
                    end
                end else if (q == m_pos[i] - 1) begin
                    m_pos[i] = q;
                    if (q == 0) to_idle[i] = 1;
                end
            end
            if (arrive[i]) begin
                m_gate[i] = 1; m_hold[i] = 0;
            end else if (to_idle[i]) begin
                m_hold[i] = GATE_HOLD;
            end else if (m_hold[i] > 0) begin
                if (m_hold[i] == 1) m_gate[i] = 0;
                m_hold[i]--;
            end
        end
        serve_e = m_pend[0] && (!m_pend[1] || !m_rr);
        serve_x = m_pend[1] && (!m_pend[0] || m_rr);
        if (m_pend[0] && m_pend[1]) m_rr = !m_rr;
        counter_apply();
        m_inc = serve_e;
        m_dec = serve_x;
        m_pend[0] = (m_pend[0] && !serve_e) || comp[0];
        m_pend[1] = (m_pend[1] && !serve_x) || (comp[1] && eff != 0);
        if (comp[1] && eff == 0) m_uf = 1;
        m_full  = (eff >= CAPACITY);
        m_empty = (eff == 0);
    endtask

    task automatic check_outputs();
        chk("inc", inc, m_inc);
        chk("dec", dec, m_dec);
        chk("inc_dec_excl", inc & dec, 0);
        chk("ent_gate", ent_gate, m_gate[0]);
        chk("ext_gate", ext_gate, m_gate[1]);
        chk("full", full, m_full);
        chk("empty", empty, m_empty);
        chk("underflow_err", underflow_err, m_uf);
`ifdef LOT_STATS_EN
        chk("total_entries", total_entries, m_total);
        chk("denied_count", denied_count, m_denied);
`endif
    endtask

    task automatic drive(input bit ea, input bit eb, input bit xa, input bit xb);
        ent_a = ea; ent_b = eb; ext_a = xa; ext_b = xb;
    endtask

    task automatic set_occ(input int v);
        m_occ = v;
        occupancy = CW'(v);
    endtask

    // One clock: a completion must never coincide with its own lane's pend flag.
    task automatic tick();
        #1;
        if (!reset) begin
            checks++;
            assert (!(dut.ent_done && dut.ent_pend_q) && !(dut.ext_done && dut.ext_pend_q)) else begin
                errors++;
                $error("FAIL pend_overlap: observed completion with pend set, expected none");
            end
        end
        @(posedge clk);
        if (reset) model_reset();
        else model_update();
        @(negedge clk);
        check_outputs();
        occupancy = CW'(m_occ);
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    int cur_idx[2];
    int r;

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0);
        set_occ(0);
        model_reset();
        tick();
        tick();
        chk("rst_empty", empty, 1);
        chk("rst_inc", inc, 0);
        chk("rst_ent_gate", ent_gate, 0);
        chk("rst_full", full, 0);
        reset = 1'b0;

        // Normal entry with 3 cars parked.
        set_occ(3);
        idle(1);
        drive(1, 0, 0, 0); tick();
        chk("entry_gate_open", ent_gate, 1);
        drive(1, 1, 0, 0); tick();
        drive(0, 1, 0, 0); tick();
        drive(0, 0, 0, 0); tick();
        chk("entry_inc_not_yet", inc, 0);
        tick();
        chk("entry_inc_pulse", inc, 1);
        tick();
        chk("entry_inc_single", inc, 0);
        tick();
        chk("entry_gate_held", ent_gate, 1);
        tick();
        chk("entry_gate_closed", ent_gate, 0);

        // Abort and backing out: gate cycles, no count change.
        drive(1, 0, 0, 0); tick();
        chk("abort_gate_open", ent_gate, 1);
        idle(GATE_HOLD + 1);
        chk("abort_gate_closed", ent_gate, 0);
        drive(1, 0, 0, 0); tick();
        drive(1, 1, 0, 0); tick();
        drive(1, 0, 0, 0); tick();
        idle(GATE_HOLD + 2);
        chk("backout_no_inc", inc, 0);
        chk("backout_gate_closed", ent_gate, 0);

        // Lot full: arrival is refused.
        set_occ(CAPACITY);
        idle(2);
        chk("full_flag", full, 1);
        drive(1, 0, 0, 0); tick();
        chk("full_gate_shut", ent_gate, 0);
        chk("full_blocked_state", {29'd0, ent_state_dbg_o}, 32'd4);
        drive(1, 1, 0, 0); tick();
        drive(0, 1, 0, 0); tick();
        idle(3);
        chk("full_no_inc", inc, 0);
`ifdef LOT_STATS_EN
        chk("full_denied_one", denied_count, 1);
`endif

        // Simultaneous completions: round-robin alternates winner.
        set_occ(10);
        idle(2);
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 1, 0); tick();
            drive(1, 1, 1, 1); tick();
            drive(0, 1, 0, 1); tick();
            drive(0, 0, 0, 0); tick();
            tick();
            chk("rr_first_inc", inc, (k == 0) ? 1 : 0);
            chk("rr_first_dec", dec, (k == 0) ? 0 : 1);
            tick();
            chk("rr_second_inc", inc, (k == 0) ? 0 : 1);
            chk("rr_second_dec", dec, (k == 0) ? 1 : 0);
            idle(GATE_HOLD + 1);
        end

        // Exit from an empty lot.
        set_occ(0);
        idle(2);
        drive(0, 0, 1, 0); tick();
        drive(0, 0, 1, 1); tick();
        drive(0, 0, 0, 1); tick();
        drive(0, 0, 0, 0); tick();
        chk("uf_set", underflow_err, 1);
        tick();
        chk("uf_no_dec", dec, 0);
        idle(4);
        chk("uf_sticky", underflow_err, 1);

        // Reset mid-passage drops the car.
        reset = 1'b1; tick(); reset = 1'b0;
        chk("uf_cleared", underflow_err, 0);
        set_occ(5);
        drive(1, 0, 0, 0); tick();
        drive(1, 1, 0, 0); tick();
        reset = 1'b1; tick();
        chk("midrst_gate", ent_gate, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_inc", inc, 0);
        reset = 1'b0;
        drive(0, 1, 0, 0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0); tick();
            chk("midrst_no_inc", inc, 0);
        end

        // Random traffic on both lanes.
        cur_idx[0] = 0; cur_idx[1] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 2; i++) begin
                r = $urandom_range(0, 9);
                if (r <= 4)      cur_idx[i] = (cur_idx[i] + 1) % 4;
                else if (r == 7) cur_idx[i] = (cur_idx[i] + 3) % 4;
                else if (r == 8) cur_idx[i] = $urandom_range(0, 3);
            end
            drive(cur_idx[0] == 1 || cur_idx[0] == 2, cur_idx[0] == 2 || cur_idx[0] == 3,
                  cur_idx[1] == 1 || cur_idx[1] == 2, cur_idx[1] == 2 || cur_idx[1] == 3);
            if (!m_pend[0] && !m_pend[1] && !m_inc && !m_dec && $urandom_range(0, 49) == 0)
                set_occ($urandom_range(0, CAPACITY));
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
